// File: rtl/spi_pp_pkg.sv
// spi_pp_pkg: shared types for the SPI ping-pong slave.
package spi_pp_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] byte_t;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_e;

  // The read bank is always the one not currently being filled.
  function automatic bank_e other_bank(input bank_e b);
    return (b == BANK_A) ? BANK_B : BANK_A;
  endfunction

endpackage

// File: rtl/spi_pp_bank_ram.sv
// spi_pp_bank_ram: two banks of DEPTH bytes, one synchronous write port and
// one combinational read port, both addressed by {bank, ptr}.
module spi_pp_bank_ram
  import spi_pp_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  byte_t mem [2*DEPTH];

  // Store a completed receive byte.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  // Combinational read so the tx register can load in the same cycle.
  assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/spi_pingpong_slave.sv
// spi_pingpong_slave: SPI mode-0 slave collecting received bytes into a
// ping-pong buffer and streaming the completed bank back on miso.
// bank_sel names the bank being written; the other bank is read.
// Build option: SPI_PP_OVERWRITE_EN -- a full write bank swaps in even while
// the read bank still holds unread data (unread bytes are lost). Without it,
// the full bank waits and further received bytes are dropped.
module spi_pingpong_slave
  import spi_pp_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic ssel,
  input  logic mosi,
  output logic miso,
  output logic DRDY
);

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

  logic sck_s1, sck_s2, sck_h;
  logic ssel_s1, ssel_s2, ssel_h;
  logic mosi_s1, mosi_s2;

  logic [2:0]        bitcnt;
  byte_t             rx_shift, tx_shift, rx_byte, rd_data;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  bank_e             bank_sel;
  logic              wrap_q, pend_full, swap;
  logic              sck_rise, sck_fall, ssel_fall, selected;
  logic              wr_en, tx_load, rd_last;

  assign selected  = ~ssel_s2;
  assign sck_rise  = sck_s2 & ~sck_h;
  assign sck_fall  = ~sck_s2 & sck_h;
  assign ssel_fall = ~ssel_s2 & ssel_h;
  assign rx_byte   = {rx_shift[DATA_W-2:0], mosi_s2};
  assign wr_en     = selected & sck_rise & (bitcnt == 3'd7) & ~pend_full;
  assign tx_load   = ssel_fall | (selected & sck_fall & (bitcnt == 3'd0));
  assign rd_last   = tx_load & DRDY & (rd_ptr == PTR_LAST);
  assign miso      = tx_shift[DATA_W-1];

  // Two-flop synchronisers plus history flops for edge detection.
  // ssel syncs reset high so reset does not look like a select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {sck_s1, sck_s2, sck_h}    <= 3'b000;
      {ssel_s1, ssel_s2, ssel_h} <= 3'b111;
      {mosi_s1, mosi_s2}         <= 2'b00;
    end else begin
      sck_s1  <= sck;
      sck_s2  <= sck_s1;
      sck_h   <= sck_s2;
      ssel_s1 <= ssel;
      ssel_s2 <= ssel_s1;
      ssel_h  <= ssel_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  // Receive shifter, bit counter and write pointer; wrap_q flags a full bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift <= '0;
      bitcnt   <= 3'd0;
      wr_ptr   <= '0;
      wrap_q   <= 1'b0;
    end else begin
      if (!selected) begin
        bitcnt <= 3'd0;
      end else if (sck_rise) begin
        rx_shift <= rx_byte;
        bitcnt   <= bitcnt + 3'd1;
      end
      if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
      wrap_q <= wr_en & (wr_ptr == PTR_LAST);
    end
  end

`ifdef SPI_PP_OVERWRITE_EN
  assign pend_full = 1'b0;
  assign swap      = wrap_q;
`else
  // A wrap coinciding with the last read load counts as a freed read bank.
  assign swap = (wrap_q & (~DRDY | rd_last)) | (pend_full & ~DRDY);

  // Full write bank waiting for the read bank to drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
    end else if (swap) begin
      pend_full <= 1'b0;
    end else if (wrap_q & DRDY & ~rd_last) begin
      pend_full <= 1'b1;
    end
  end
`endif

  // Transmit register, read pointer, bank select and DRDY; a swap overrides
  // the pointer and DRDY updates of a same-cycle load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '0;
      rd_ptr   <= '0;
      bank_sel <= BANK_A;
      DRDY     <= 1'b0;
    end else begin
      if (tx_load) begin
        if (DRDY) begin
          tx_shift <= rd_data;
          rd_ptr   <= rd_ptr + ADDR_W'(1);
          if (rd_ptr == PTR_LAST) DRDY <= 1'b0;
        end else begin
          tx_shift <= '0;
        end
      end else if (!selected) begin
        tx_shift <= '0;
      end else if (sck_fall) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
      if (swap) begin
        bank_sel <= other_bank(bank_sel);
        DRDY     <= 1'b1;
        rd_ptr   <= '0;
      end
    end
  end

  spi_pp_bank_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_bank (bank_sel),
    .wr_addr (wr_ptr),
    .wr_data (rx_byte),
    .rd_bank (other_bank(bank_sel)),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_spi_pingpong_slave.sv
// tb_spi_pingpong_slave: drives SPI bursts into a DEPTH=4 slave, predicts the
// miso bytes and DRDY with a byte-level buffer model, and scoreboards them.
module tb_spi_pingpong_slave;

  localparam int D = 4;
  localparam int H = 6;  // sck half period in clk cycles

  logic clk = 1'b0;
  logic rst_n, sck, ssel, mosi;
  logic miso, DRDY;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] exp_q [$];
  logic [7:0] tx_q [$];

  // reference buffer model
  logic [7:0] m_bank [2][D];
  int m_wsel, m_rd, m_wr;
  bit m_drdy, m_pend;

  spi_pingpong_slave #(.DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sck   (sck),
    .ssel  (ssel),
    .mosi  (mosi),
    .miso  (miso),
    .DRDY  (DRDY)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h required 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic void m_reset();
    m_wsel = 0; m_rd = 0; m_wr = 0; m_drdy = 0; m_pend = 0;
  endfunction

  function automatic void m_swap();
    m_wsel = m_wsel ^ 1; m_drdy = 1; m_rd = 0; m_pend = 0;
  endfunction

  function automatic void m_write(input logic [7:0] b);
    if (m_pend) return;
    m_bank[m_wsel][m_wr] = b;
    m_wr++;
    if (m_wr == D) begin
      m_wr = 0;
`ifdef SPI_PP_OVERWRITE_EN
      m_swap();
`else
      if (!m_drdy) m_swap();
      else m_pend = 1;
`endif
    end
  endfunction

  function automatic logic [7:0] m_load();
    logic [7:0] v;
    v = 8'h00;
    if (m_drdy) begin
      v = m_bank[m_wsel ^ 1][m_rd];
      m_rd++;
      if (m_rd == D) begin
        m_rd = 0;
        m_drdy = 0;
      end
    end
    if (m_pend && !m_drdy) m_swap();
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One byte; on the last byte of a burst ssel rises before the final sck fall.
  task automatic xfer_byte(input logic [7:0] tx, input bit last,
                           output logic [7:0] rx, output int lat);
    bit prev;
    lat = 0;
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      tick(H);
      rx[i] = miso;
      sck = 1'b1;
      if (i == 0) begin
        prev = DRDY;
        for (int c = 1; c <= H; c++) begin
          tick(1);
          if (lat == 0 && !prev && DRDY) lat = c;
          prev = DRDY;
        end
        if (last) begin
          ssel = 1'b1;
          tick(4);
        end
      end else begin
        tick(H);
      end
      sck = 1'b0;
    end
  endtask

  // Sends tx_q as one burst; lat reports DRDY rise delay after a last sck rise.
  task automatic burst(output int lat);
    logic [7:0] rx;
    int l;
    int n;
    n = tx_q.size();
    lat = 0;
    ssel = 1'b0;
    exp_q.push_back(m_load());
    tick(H);
    for (int i = 0; i < n; i++) begin
      xfer_byte(tx_q[i], i == n - 1, rx, l);
      if (l != 0) lat = l;
      m_write(tx_q[i]);
      if (i != n - 1) exp_q.push_back(m_load());
      tick(5);
      if (exp_q.size() == 0) check("miso_queue", exp_q.size(), 1);
      else check("miso", rx, exp_q.pop_front());
      check("drdy", DRDY, m_drdy);
    end
    tick(H);
  endtask

  task automatic partial(input int nbits);
    ssel = 1'b0;
    void'(m_load());
    tick(H);
    for (int i = 0; i < nbits; i++) begin
      mosi = i[0];
      tick(H);
      sck = 1'b1;
      tick(H);
      sck = 1'b0;
    end
    tick(2);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; sck = 1'b0; ssel = 1'b1; mosi = 1'b0;
    m_reset();
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("reset_miso", miso, 0);
    check("reset_drdy", DRDY, 0);

    tx_q = {8'hA5};
    burst(lat);

    // reset in the middle of a byte
    partial(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    m_reset();
    exp_q.delete();
    ssel = 1'b1;
    tick(6);
    check("rst_bitcnt", dut.bitcnt, 0);
    check("rst_wr_ptr", dut.wr_ptr, 0);
    check("rst_drdy", DRDY, 0);
    check("rst_miso", miso, 0);

    // first fill
    tx_q = {8'h11, 8'h22, 8'h33, 8'h44};
    burst(lat);
    check("drdy_latency_ok", (lat >= 4 && lat <= 5), 1);

    // read back while refilling
    tx_q = {8'h55, 8'h66, 8'h77, 8'h88};
    burst(lat);
    check("drdy_latency_ok", (lat >= 4 && lat <= 5), 1);

    // partial byte is discarded
    partial(5);
    ssel = 1'b1;
    tick(6);
    sck = 1'b0;
    check("partial_bitcnt", dut.bitcnt, 0);
    check("partial_wr_ptr", dut.wr_ptr, m_wr);

    tx_q = {8'h99};
    burst(lat);
    tx_q = {8'hAA, 8'hBB, 8'hCC};
    burst(lat);
    tx_q = {8'hD1, 8'hD2, 8'hD3, 8'hD4};
    burst(lat);

    tx_q.delete();
    for (int i = 0; i < 7; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    burst(lat);
    tx_q = {8'h0F, 8'hF0};
    burst(lat);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
